// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity encodings,
// receiver state encoding and the default oversample divisor.
// 26 gives 115200 baud x16 oversampling from a 50 MHz clk (50e6/(16*115200) ~= 27 cycles).
package uart_pkg;

    // parity_mode encodings (2'b11 behaves as none)
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Receiver state encoding, kept as plain constants for legacy compatibility
    typedef logic [2:0] rx_state_t;
    localparam rx_state_t ST_IDLE       = 3'd0;
    localparam rx_state_t ST_START      = 3'd1;
    localparam rx_state_t ST_DATA       = 3'd2;
    localparam rx_state_t ST_PARITY     = 3'd3;
    localparam rx_state_t ST_STOP       = 3'd4;
    localparam rx_state_t ST_BREAK_WAIT = 3'd5;

    localparam int DEFAULT_DIV = 26;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: one-cycle tick every div+1 clk cycles while enabled.
// Latency: first tick div+1 cycles after clear; div=0 ticks every enabled cycle.
// Backpressure: none; counter holds its value while enable is low.
// Ports: clk, reset (async active-high), clear (restart count), enable, div, tick.
module uart_rx_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = enable && (cnt == div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == div) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-vote sampling, runtime parity/stop/divisor, valid/ready out.
// Latency: word presented 1 clk after the final stop-bit vote (mid stop bit).
// Backpressure: one-word holding register; a frame completing while it is full is dropped (overrun pulse).
// Ports: clk, reset, baud_div, parity_mode, stop_bits, rx_in -> m_data/m_valid/m_ready,
//        frame_err, parity_err, overrun, busy.
// Optional: UART_RX_BREAK_DETECT_EN adds break_det and swallows all-zero frames as breaks.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int VOTE_N     = 5,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                 break_det
`endif
);

    localparam int OS_W    = $clog2(OVERSAMPLE);
    localparam int CNT_W   = $clog2(VOTE_N + 1);
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam int V_HALF  = VOTE_N / 2;
    localparam int V_FIRST = OVERSAMPLE / 2 - V_HALF;
    localparam int V_LAST  = OVERSAMPLE / 2 + V_HALF;

    // Synchroniser and edge detector all reset to idle-high
    logic [1:0] sync_q;
    logic       rx_s;
    logic       rx_prev;

    rx_state_t          state;
    logic [OS_W-1:0]    os_cnt;
    logic [CNT_W-1:0]   ones;
    logic [CNT_W-1:0]   ones_nxt;
    logic [IDX_W-1:0]   bit_idx;
    logic               stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic               par_bit;
    logic               fe_acc;
    logic               fin_fe;
    logic               fin_pe;
    logic               deliver_q;

    // Per-frame configuration, frozen at the start edge
    logic [DIV_W-1:0]   cfg_div;
    logic [1:0]         cfg_par;
    logic               cfg_two_stop;

`ifdef UART_RX_BREAK_DETECT_EN
    logic               all_zero;
    logic [OS_W-1:0]    hi_cnt;
`endif

    logic start_edge;
    logic tick;
    logic in_win;
    logic vote;
    logic vote_pt;
    logic bit_end;
    logic par_en;
    logic par_calc;
    logic par_err_calc;

    assign rx_s       = sync_q[1];
    assign start_edge = (state == ST_IDLE) && rx_prev && !rx_s;
    assign busy       = (state != ST_IDLE);

    uart_rx_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_edge),
        .enable (busy),
        .div    (cfg_div),
        .tick   (tick)
    );

    assign in_win  = (os_cnt >= OS_W'(V_FIRST)) && (os_cnt <= OS_W'(V_LAST));
    assign vote_pt = (os_cnt == OS_W'(V_LAST));
    assign bit_end = (os_cnt == OS_W'(OVERSAMPLE - 1));

    // Vote includes the sample taken on the current (last window) tick
    always_comb begin
        ones_nxt = ones;
        if (in_win && rx_s) ones_nxt = ones + 1'b1;
    end
    assign vote = (ones_nxt > CNT_W'(V_HALF));

    assign par_en   = (cfg_par == PAR_EVEN) || (cfg_par == PAR_ODD);
    assign par_calc = (^shreg) ^ par_bit;

    always_comb begin
        par_err_calc = 1'b0;
        if (cfg_par == PAR_EVEN)     par_err_calc = par_calc;
        else if (cfg_par == PAR_ODD) par_err_calc = !par_calc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], rx_in};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            os_cnt       <= '0;
            ones         <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            fe_acc       <= 1'b0;
            fin_fe       <= 1'b0;
            fin_pe       <= 1'b0;
            deliver_q    <= 1'b0;
            cfg_div      <= '0;
            cfg_par      <= PAR_NONE;
            cfg_two_stop <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero     <= 1'b0;
            hi_cnt       <= '0;
            break_det    <= 1'b0;
`endif
        end else begin
            deliver_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            break_det <= 1'b0;
`endif
            if (start_edge) begin
                state        <= ST_START;
                os_cnt       <= '0;
                ones         <= '0;
                bit_idx      <= '0;
                stop_idx     <= 1'b0;
                fe_acc       <= 1'b0;
                cfg_div      <= baud_div;
                cfg_par      <= parity_mode;
                cfg_two_stop <= stop_bits;
`ifdef UART_RX_BREAK_DETECT_EN
                all_zero     <= 1'b1;
`endif
            end else if (tick) begin
                if (bit_end) begin
                    os_cnt <= '0;
                    ones   <= '0;
                end else begin
                    os_cnt <= os_cnt + 1'b1;
                    ones   <= ones_nxt;
                end
`ifdef UART_RX_BREAK_DETECT_EN
                if (vote_pt) all_zero <= all_zero & !vote;
`endif
                case (state)
                    ST_START: begin
                        // A start bit that votes high was noise: abandon the frame
                        if (vote_pt && vote) state <= ST_IDLE;
                        else if (bit_end)    state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (vote_pt) shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (bit_end) begin
                            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                                bit_idx <= '0;
                                state   <= par_en ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (vote_pt) par_bit <= vote;
                        if (bit_end) state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (vote_pt) begin
                            if (cfg_two_stop && !stop_idx) begin
                                fe_acc <= fe_acc | !vote;
                            end else begin
                                // Leave mid-bit so a back-to-back start edge is not missed
                                fin_fe <= fe_acc | !vote;
                                fin_pe <= par_err_calc;
`ifdef UART_RX_BREAK_DETECT_EN
                                if (all_zero && !vote) begin
                                    state     <= ST_BREAK_WAIT;
                                    hi_cnt    <= '0;
                                    break_det <= 1'b1;
                                end else begin
                                    state     <= ST_IDLE;
                                    deliver_q <= 1'b1;
                                end
`else
                                state     <= ST_IDLE;
                                deliver_q <= 1'b1;
`endif
                            end
                        end else if (bit_end) begin
                            stop_idx <= 1'b1;
                        end
                    end
`ifdef UART_RX_BREAK_DETECT_EN
                    ST_BREAK_WAIT: begin
                        // Need one full bit time of continuous high before re-arming
                        if (!rx_s)                                    hi_cnt <= '0;
                        else if (hi_cnt == OS_W'(OVERSAMPLE - 1))     state  <= ST_IDLE;
                        else                                          hi_cnt <= hi_cnt + 1'b1;
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Single-entry output register with overrun on a full, unaccepted slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver_q) begin
                if (!m_valid || m_ready) begin
                    m_data     <= shreg;
                    frame_err  <= fin_fe;
                    parity_err <= fin_pe;
                    m_valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
